// File: rtl/instr_encode_loader.sv
// instr_encode_loader: re-encodes decoded RV32I fields into
// instruction words and streams them into instruction memory.
module instr_encode_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              START,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [6:0]        OPCODE,
  input  logic [2:0]        FUNCT3,
  input  logic [6:0]        FUNCT7,
  input  logic [4:0]        RS1,
  input  logic [4:0]        RS2,
  input  logic [4:0]        RD,
  input  logic [31:0]       IMM,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [31:0]       MEM_WDATA,
  input  logic              MEM_READY,
  output logic              ERR,
  output logic [ADDR_W:0]   COUNT,
  output logic              FULL
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
  } fields_t;

  fields_t            s1_q;
  logic               s1_v;
  logic               s2_v;
  logic [31:0]        s2_word;
  logic [ADDR_W:0]    count;
  logic [ADDR_W:0]    count_nxt;
  logic [ADDR_W+1:0]  used;
  logic               live;
  logic               err_q;
  logic               full_q;
  logic [31:0]        enc_word;
  logic               enc_known;
  logic               is_shift;
  logic               wr_done;
  logic               s1_go;
  logic               room;
  logic               accept;

  // Re-encode the bundle held in S1 into its instruction word
  always_comb begin
    enc_word  = '0;
    enc_known = 1'b1;
    is_shift  = (s1_q.funct3 == 3'b001) ||
                (s1_q.funct3 == 3'b101);
    unique case (s1_q.opcode)
      OP_LUI, OP_AUIPC:
        enc_word = {s1_q.imm[31:12], s1_q.rd,
                    s1_q.opcode};
      OP_JAL:
        enc_word = {s1_q.imm[20], s1_q.imm[10:1],
                    s1_q.imm[11], s1_q.imm[19:12],
                    s1_q.rd, s1_q.opcode};
      OP_JALR, OP_LOAD:
        enc_word = {s1_q.imm[11:0], s1_q.rs1,
                    s1_q.funct3, s1_q.rd,
                    s1_q.opcode};
      OP_IMM:
        if (is_shift)
          enc_word = {s1_q.funct7, s1_q.rs2,
                      s1_q.rs1, s1_q.funct3,
                      s1_q.rd, s1_q.opcode};
        else
          enc_word = {s1_q.imm[11:0], s1_q.rs1,
                      s1_q.funct3, s1_q.rd,
                      s1_q.opcode};
      OP_STORE:
        enc_word = {s1_q.imm[11:5], s1_q.rs2,
                    s1_q.rs1, s1_q.funct3,
                    s1_q.imm[4:0], s1_q.opcode};
      OP_BRANCH:
        enc_word = {s1_q.imm[12], s1_q.imm[10:5],
                    s1_q.rs2, s1_q.rs1,
                    s1_q.funct3, s1_q.imm[4:1],
                    s1_q.imm[11], s1_q.opcode};
      OP_REG:
        enc_word = {s1_q.funct7, s1_q.rs2,
                    s1_q.rs1, s1_q.funct3,
                    s1_q.rd, s1_q.opcode};
      default:
        enc_known = 1'b0;
    endcase
  end

  // Handshake and capacity: a bad bundle always leaves S1,
  // a good one needs S2 empty or draining this cycle
  always_comb begin
    wr_done   = s2_v && MEM_READY && !START;
    s1_go     = s1_v && (!enc_known || !s2_v || wr_done);
    used      = {1'b0, count}
              + {{(ADDR_W+1){1'b0}}, s1_v}
              + {{(ADDR_W+1){1'b0}}, s2_v};
    room      = used < {1'b0, CAP};
    IN_READY  = live && !START && room &&
                (!s1_v || s1_go);
    accept    = IN_VALID && IN_READY;
    count_nxt = count + {{ADDR_W{1'b0}}, wr_done};
  end

  // Hold IN_READY low until the first edge out of reset
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) live <= 1'b0;
    else       live <= 1'b1;
  end

  // S1: capture accepted bundle, release when it moves on
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      s1_v <= 1'b0;
      s1_q <= '0;
    end else if (START) begin
      s1_v <= 1'b0;
    end else if (accept) begin
      s1_v <= 1'b1;
      s1_q <= '{opcode: OPCODE, funct3: FUNCT3,
                funct7: FUNCT7, rs1: RS1, rs2: RS2,
                rd: RD, imm: IMM};
    end else if (s1_go) begin
      s1_v <= 1'b0;
    end
  end

  // S2: hold the encoded word until memory takes it
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      s2_v    <= 1'b0;
      s2_word <= '0;
    end else if (START) begin
      s2_v <= 1'b0;
    end else if (s1_go && enc_known) begin
      s2_v    <= 1'b1;
      s2_word <= enc_word;
    end else if (wr_done) begin
      s2_v <= 1'b0;
    end
  end

  // Written-word count, sticky error and full flag
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      count  <= '0;
      err_q  <= 1'b0;
      full_q <= 1'b0;
    end else if (START) begin
      count  <= '0;
      err_q  <= 1'b0;
      full_q <= 1'b0;
    end else begin
      count  <= count_nxt;
      full_q <= (count_nxt == CAP);
      if (s1_v && !enc_known) err_q <= 1'b1;
    end
  end

  assign MEM_WE    = s2_v && !START;
  assign MEM_WDATA = s2_word;
  assign MEM_ADDR  = BASE + count[ADDR_W-1:0];
  assign COUNT     = count;
  assign ERR       = err_q;
  assign FULL      = full_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// tb_instr_encode_loader: directed vectors for the encoder/loader,
// a 1024-word instance and a 4-word instance at base 2.
module tb_instr_encode_loader;

  logic clk = 0, rstn = 0, start = 0;
  logic in_valid = 0, mem_ready = 0;
  logic [6:0] opcode = 0, funct7 = 0;
  logic [2:0] funct3 = 0;
  logic [4:0] rs1 = 0, rs2 = 0, rd = 0;
  logic [31:0] imm = 0;

  logic rdy_a, we_a, err_a, full_a;
  logic [9:0] addr_a;
  logic [31:0] wdata_a;
  logic [10:0] count_a;

  logic rdy_b, we_b, err_b, full_b;
  logic [1:0] addr_b;
  logic [31:0] wdata_b;
  logic [2:0] count_b;

  int n_cmp = 0, n_err = 0, cyc = 0;

  typedef struct {
    int addr;
    logic [31:0] data;
    int cyc;
  } wr_t;
  wr_t qa[$], qb[$];

  instr_encode_loader dut_a (
    .CLK(clk), .RSTN(rstn), .START(start),
    .IN_VALID(in_valid), .IN_READY(rdy_a),
    .OPCODE(opcode), .FUNCT3(funct3), .FUNCT7(funct7),
    .RS1(rs1), .RS2(rs2), .RD(rd), .IMM(imm),
    .MEM_WE(we_a), .MEM_ADDR(addr_a),
    .MEM_WDATA(wdata_a), .MEM_READY(mem_ready),
    .ERR(err_a), .COUNT(count_a), .FULL(full_a));

  instr_encode_loader #(.ADDR_W(2), .BASE_ADDR(2)) dut_b (
    .CLK(clk), .RSTN(rstn), .START(start),
    .IN_VALID(in_valid), .IN_READY(rdy_b),
    .OPCODE(opcode), .FUNCT3(funct3), .FUNCT7(funct7),
    .RS1(rs1), .RS2(rs2), .RD(rd), .IMM(imm),
    .MEM_WE(we_b), .MEM_ADDR(addr_b),
    .MEM_WDATA(wdata_b), .MEM_READY(mem_ready),
    .ERR(err_b), .COUNT(count_b), .FULL(full_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we_a && mem_ready)
      qa.push_back('{int'(addr_a), wdata_a, cyc});
    if (we_b && mem_ready)
      qb.push_back('{int'(addr_b), wdata_b, cyc});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_f(input logic [6:0] op,
                       input logic [2:0] f3,
                       input logic [6:0] f7,
                       input logic [4:0] r1,
                       input logic [4:0] r2,
                       input logic [4:0] d,
                       input logic [31:0] im);
    opcode = op; funct3 = f3; funct7 = f7;
    rs1 = r1; rs2 = r2; rd = d; imm = im;
  endtask

  task automatic load_addi(input int k);
    set_f(7'h13, 3'd0, 7'd0, 5'd0, 5'd0,
          5'(k), 32'(k));
  endtask

  task automatic send_a(input logic [6:0] op,
                        input logic [2:0] f3,
                        input logic [6:0] f7,
                        input logic [4:0] r1,
                        input logic [4:0] r2,
                        input logic [4:0] d,
                        input logic [31:0] im);
    bit ok = 0;
    set_f(op, f3, f7, r1, r2, d, im);
    in_valid = 1;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (rdy_a) ok = 1;
      cycle();
    end
    in_valid = 0;
    n_cmp++;
    if (ok !== 1'b1) begin
      n_err++;
      $display("FAIL send_accept: got %0b want 1", ok);
    end
  endtask

  task automatic do_start();
    start = 1;
    cycle();
    start = 0;
    qa.delete();
    qb.delete();
  endtask

  task automatic test_reset();
    rstn = 0;
    #3;
    n_cmp++; if (rdy_a !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", rdy_a); end
    n_cmp++; if (we_a !== 1'b0) begin n_err++; $display("FAIL rst_we: got %b want 0", we_a); end
    n_cmp++; if (addr_a !== 10'd0) begin n_err++; $display("FAIL rst_addr: got %h want 0", addr_a); end
    n_cmp++; if (wdata_a !== 32'd0) begin n_err++; $display("FAIL rst_wdata: got %h want 0", wdata_a); end
    n_cmp++; if (err_a !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", err_a); end
    n_cmp++; if (count_a !== 11'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", count_a); end
    n_cmp++; if (full_a !== 1'b0) begin n_err++; $display("FAIL rst_full: got %b want 0", full_a); end
    n_cmp++; if (addr_b !== 2'd2) begin n_err++; $display("FAIL rst_addr_b: got %0d want 2", addr_b); end
    repeat (2) @(posedge clk);
    #1 rstn = 1;
    #1;
    n_cmp++; if (rdy_a !== 1'b0) begin n_err++; $display("FAIL rel_ready_early: got %b want 0", rdy_a); end
    cycle();
    n_cmp++; if (rdy_a !== 1'b1) begin n_err++; $display("FAIL rel_ready: got %b want 1", rdy_a); end
    n_cmp++; if (rdy_b !== 1'b1) begin n_err++; $display("FAIL rel_ready_b: got %b want 1", rdy_b); end
  endtask

  task automatic test_lui();
    mem_ready = 1;
    qa.delete();
    send_a(7'h37, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'hFFFFF000);
    n_cmp++; if (we_a !== 1'b0) begin n_err++; $display("FAIL lui_we_n1: got %b want 0", we_a); end
    cycle();
    n_cmp++; if (we_a !== 1'b1) begin n_err++; $display("FAIL lui_we: got %b want 1", we_a); end
    n_cmp++; if (addr_a !== 10'd0) begin n_err++; $display("FAIL lui_addr: got %0d want 0", addr_a); end
    n_cmp++; if (wdata_a !== 32'hFFFFF0B7) begin n_err++; $display("FAIL lui_wdata: got %h want FFFFF0B7", wdata_a); end
    cycle();
    n_cmp++; if (count_a !== 11'd1) begin n_err++; $display("FAIL lui_count: got %0d want 1", count_a); end
    n_cmp++; if (qa.size() !== 1) begin n_err++; $display("FAIL lui_nwr: got %0d want 1", qa.size()); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [5] = '{32'hFEC00093, 32'h00208463,
      32'h001000EF, 32'h0020A223, 32'h402081B3};
    do_start();
    mem_ready = 1;
    send_a(7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, -32'sd20);
    send_a(7'h63, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd8);
    send_a(7'h6F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'h800);
    send_a(7'h23, 3'd2, 7'd0, 5'd1, 5'd2, 5'd0, 32'd4);
    send_a(7'h33, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 32'd0);
    repeat (4) cycle();
    n_cmp++; if (qa.size() !== 5) begin n_err++; $display("FAIL b2b_nwr: got %0d want 5", qa.size()); end
    for (int i = 0; i < qa.size() && i < 5; i++) begin
      n_cmp++; if (qa[i].addr !== i) begin n_err++; $display("FAIL b2b_addr%0d: got %0d want %0d", i, qa[i].addr, i); end
      n_cmp++; if (qa[i].data !== exp[i]) begin n_err++; $display("FAIL b2b_data%0d: got %h want %h", i, qa[i].data, exp[i]); end
      n_cmp++; if (qa[i].cyc - qa[0].cyc !== i) begin n_err++; $display("FAIL b2b_rate%0d: got %0d want %0d", i, qa[i].cyc - qa[0].cyc, i); end
    end
  endtask

  task automatic test_backpressure();
    int idx = 0, acc = 0;
    bit take, seen = 0, stable = 1;
    logic [9:0] a0 = 0;
    logic [31:0] d0 = 0;
    logic [31:0] exp [3] = '{32'h00100093, 32'h00200113,
                             32'h00300193};
    do_start();
    mem_ready = 0;
    load_addi(1);
    in_valid = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      take = in_valid && rdy_a;
      if (we_a) begin
        if (!seen) begin
          seen = 1; a0 = addr_a; d0 = wdata_a;
        end else if (addr_a !== a0 || wdata_a !== d0) begin
          stable = 0;
        end
      end
      cycle();
      if (take) begin
        acc++; idx++;
        if (idx < 3) load_addi(idx + 1);
        else in_valid = 0;
      end
    end
    n_cmp++; if (acc !== 2) begin n_err++; $display("FAIL bp_accepted: got %0d want 2", acc); end
    n_cmp++; if (rdy_a !== 1'b0) begin n_err++; $display("FAIL bp_ready: got %b want 0", rdy_a); end
    n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL bp_we_seen: got %b want 1", seen); end
    n_cmp++; if (stable !== 1'b1) begin n_err++; $display("FAIL bp_stable: got %b want 1", stable); end
    n_cmp++; if (d0 !== exp[0]) begin n_err++; $display("FAIL bp_held_data: got %h want %h", d0, exp[0]); end
    n_cmp++; if (qa.size() !== 0) begin n_err++; $display("FAIL bp_no_write: got %0d want 0", qa.size()); end
    mem_ready = 1;
    for (int c = 0; c < 20 && idx < 3; c++) begin
      @(negedge clk);
      take = in_valid && rdy_a;
      cycle();
      if (take) begin
        idx++;
        if (idx < 3) load_addi(idx + 1);
        else in_valid = 0;
      end
    end
    in_valid = 0;
    repeat (4) cycle();
    n_cmp++; if (qa.size() !== 3) begin n_err++; $display("FAIL bp_nwr: got %0d want 3", qa.size()); end
    for (int i = 0; i < qa.size() && i < 3; i++) begin
      n_cmp++; if (qa[i].addr !== i) begin n_err++; $display("FAIL bp_addr%0d: got %0d want %0d", i, qa[i].addr, i); end
      n_cmp++; if (qa[i].data !== exp[i]) begin n_err++; $display("FAIL bp_data%0d: got %h want %h", i, qa[i].data, exp[i]); end
    end
  endtask

  task automatic test_error();
    do_start();
    mem_ready = 1;
    send_a(7'h37, 3'd0, 7'd0, 5'd0, 5'd0, 5'd2, 32'h12345000);
    send_a(7'h7F, 3'd3, 7'd1, 5'd4, 5'd5, 5'd6, 32'h55);
    send_a(7'h13, 3'd5, 7'h20, 5'd6, 5'd3, 5'd5, 32'hFFF);
    repeat (4) cycle();
    n_cmp++; if (err_a !== 1'b1) begin n_err++; $display("FAIL err_set: got %b want 1", err_a); end
    n_cmp++; if (qa.size() !== 2) begin n_err++; $display("FAIL err_nwr: got %0d want 2", qa.size()); end
    n_cmp++; if (count_a !== 11'd2) begin n_err++; $display("FAIL err_count: got %0d want 2", count_a); end
    if (qa.size() >= 2) begin
      n_cmp++; if (qa[0].data !== 32'h12345137) begin n_err++; $display("FAIL err_d0: got %h want 12345137", qa[0].data); end
      n_cmp++; if (qa[1].addr !== 1) begin n_err++; $display("FAIL err_a1: got %0d want 1", qa[1].addr); end
      n_cmp++; if (qa[1].data !== 32'h40335293) begin n_err++; $display("FAIL err_d1: got %h want 40335293", qa[1].data); end
    end
    start = 1;
    @(negedge clk);
    n_cmp++; if (rdy_a !== 1'b0) begin n_err++; $display("FAIL start_ready: got %b want 0", rdy_a); end
    cycle();
    start = 0;
    n_cmp++; if (err_a !== 1'b0) begin n_err++; $display("FAIL start_err: got %b want 0", err_a); end
    n_cmp++; if (count_a !== 11'd0) begin n_err++; $display("FAIL start_count: got %0d want 0", count_a); end
    qa.delete();
    send_a(7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd1);
    repeat (3) cycle();
    n_cmp++; if (qa.size() !== 1) begin n_err++; $display("FAIL start_nwr: got %0d want 1", qa.size()); end
    if (qa.size() >= 1) begin
      n_cmp++; if (qa[0].addr !== 0) begin n_err++; $display("FAIL start_addr: got %0d want 0", qa[0].addr); end
    end
  endtask

  task automatic test_full();
    int idx = 0;
    bit take;
    int ea [4] = '{2, 3, 0, 1};
    logic [31:0] ed [4] = '{32'h00100093, 32'h00200113,
                            32'h00300193, 32'h00400213};
    do_start();
    mem_ready = 1;
    load_addi(1);
    in_valid = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      take = in_valid && rdy_b;
      cycle();
      if (take) begin
        idx++;
        if (idx < 5) load_addi(idx + 1);
        else in_valid = 0;
      end
    end
    n_cmp++; if (idx !== 4) begin n_err++; $display("FAIL full_accepted: got %0d want 4", idx); end
    n_cmp++; if (full_b !== 1'b1) begin n_err++; $display("FAIL full_flag: got %b want 1", full_b); end
    n_cmp++; if (count_b !== 3'd4) begin n_err++; $display("FAIL full_count: got %0d want 4", count_b); end
    n_cmp++; if (rdy_b !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", rdy_b); end
    n_cmp++; if (qb.size() !== 4) begin n_err++; $display("FAIL full_nwr: got %0d want 4", qb.size()); end
    for (int i = 0; i < qb.size() && i < 4; i++) begin
      n_cmp++; if (qb[i].addr !== ea[i]) begin n_err++; $display("FAIL full_addr%0d: got %0d want %0d", i, qb[i].addr, ea[i]); end
      n_cmp++; if (qb[i].data !== ed[i]) begin n_err++; $display("FAIL full_data%0d: got %h want %h", i, qb[i].data, ed[i]); end
    end
    in_valid = 0;
  endtask

  task automatic test_rst_mid();
    do_start();
    mem_ready = 0;
    send_a(7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd1);
    cycle();
    n_cmp++; if (we_a !== 1'b1) begin n_err++; $display("FAIL mid_we_pre: got %b want 1", we_a); end
    #2 rstn = 0;
    #1;
    n_cmp++; if (we_a !== 1'b0) begin n_err++; $display("FAIL mid_we: got %b want 0", we_a); end
    n_cmp++; if (wdata_a !== 32'd0) begin n_err++; $display("FAIL mid_wdata: got %h want 0", wdata_a); end
    n_cmp++; if (addr_a !== 10'd0) begin n_err++; $display("FAIL mid_addr: got %0d want 0", addr_a); end
    n_cmp++; if (count_a !== 11'd0) begin n_err++; $display("FAIL mid_count: got %0d want 0", count_a); end
    n_cmp++; if (rdy_a !== 1'b0) begin n_err++; $display("FAIL mid_ready: got %b want 0", rdy_a); end
    n_cmp++; if (qa.size() !== 0) begin n_err++; $display("FAIL mid_nowrite: got %0d want 0", qa.size()); end
    mem_ready = 1;
    cycle();
    rstn = 1;
    cycle();
    qa.delete();
    send_a(7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd2, 32'd2);
    repeat (3) cycle();
    n_cmp++; if (qa.size() !== 1) begin n_err++; $display("FAIL mid_nwr: got %0d want 1", qa.size()); end
    if (qa.size() >= 1) begin
      n_cmp++; if (qa[0].addr !== 0) begin n_err++; $display("FAIL mid_addr_after: got %0d want 0", qa[0].addr); end
      n_cmp++; if (qa[0].data !== 32'h00200113) begin n_err++; $display("FAIL mid_data_after: got %h want 00200113", qa[0].data); end
    end
  endtask

  initial begin
    test_reset();
    test_lui();
    test_back_to_back();
    test_backpressure();
    test_error();
    test_full();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_encode_loader.md
# instr_encode_loader

Inverse of the instruction decoder: accepts decoded RV32I fields (opcode, funct3/funct7, register indices, sign-extended immediate) through a valid/ready handshake and re-encodes them into 32-bit instruction words. Encoded words are written sequentially into instruction memory through a held write port. It sits between the program-loader/self-test front end and the instruction memory, and is used to build test programs for the CPU core.

## Interface

Parameters:
- ADDR_W, 10, word-address width of instruction memory
- BASE_ADDR, 0, word address of the first write after reset or START

Ports:
- CLK  in  1  clock, rising edge
- RSTN  in  1  reset, asynchronous, active-low
- START  in  1  synchronous restart: clears pipeline, address counter, ERR, COUNT
- IN_VALID  in  1  field bundle valid
- IN_READY  out  1  block can accept a bundle this cycle
- OPCODE  in  7  instruction opcode
- FUNCT3  in  3  funct3
- FUNCT7  in  7  funct7
- RS1  in  5  source register 1
- RS2  in  5  source register 2 / shamt
- RD  in  5  destination register
- IMM  in  32  immediate, already sign-extended / byte offset
- MEM_WE  out  1  write request
- MEM_ADDR  out  ADDR_W  word address of write
- MEM_WDATA  out  32  encoded instruction
- MEM_READY  in  1  memory accepts write this cycle
- ERR  out  1  sticky: unknown opcode received
- COUNT  out  ADDR_W+1  words written since reset/START
- FULL  out  1  COUNT == 2^ADDR_W

## Operation

- Two stages: S1 registers the accepted bundle; S2 holds the encoded word and drives MEM_WE/MEM_ADDR/MEM_WDATA.
- Bundle accepted on an edge with IN_VALID && IN_READY. Write completes on an edge with MEM_WE && MEM_READY.
- Encoding by OPCODE:
  - U (0110111 LUI, 0010111 AUIPC): {IMM[31:12], RD, OPCODE}.
  - J (1101111): {IMM[20], IMM[10:1], IMM[11], IMM[19:12], RD, OPCODE}.
  - I (1100111, 0000011, 0010011): {IMM[11:0], RS1, FUNCT3, RD, OPCODE}. Exception: 0010011 with FUNCT3 001/101 uses {FUNCT7, RS2, RS1, FUNCT3, RD, OPCODE}.
  - S (0100011): {IMM[11:5], RS2, RS1, FUNCT3, IMM[4:0], OPCODE}.
  - B (1100011): {IMM[12], IMM[10:5], RS2, RS1, FUNCT3, IMM[4:1], IMM[11], OPCODE}.
  - R (0110011): {FUNCT7, RS2, RS1, FUNCT3, RD, OPCODE}.
  - IMM bits not listed are ignored. IMM[0] is dropped for J and B.
- Unknown opcode:
  - Bundle is accepted and ERR sets.
  - It is discarded in S1 and never reaches S2.
  - COUNT and the address are unchanged.
- Address counter:
  - MEM_ADDR = BASE_ADDR + COUNT[ADDR_W-1:0], modulo 2^ADDR_W.
  - Increments on each completed write.
- Capacity:
  - IN_READY = !START && (COUNT + S1 occupancy + S2 occupancy < 2^ADDR_W) && (S1 empty || S1 advances this cycle).
  - Once FULL, no further bundles are accepted until START.
- START:
  - Highest priority; S1/S2 are emptied, including a pending write, which is dropped.
  - COUNT=0, ERR=0, IN_READY=0 that cycle.

## Timing

- Reset values (RSTN low, immediately, asynchronously): IN_READY=0, MEM_WE=0, MEM_ADDR=BASE_ADDR, MEM_WDATA=0, ERR=0, COUNT=0, FULL=0, both stages empty.
- The first edge after RSTN deasserts brings IN_READY to 1.
- Latency: bundle accepted at edge N gives MEM_WE=1 with valid data after edge N+1, i.e. the write can complete at edge N+2.
- Throughput: one word per cycle while MEM_READY is held high.
- Backpressure:
  - While MEM_WE=1 and MEM_READY=0, MEM_ADDR and MEM_WDATA are held stable.
  - S1 holds its bundle; IN_READY=0 once S1 is occupied and cannot advance.
- MEM_READY while MEM_WE=0 is ignored.
- ERR sets on the edge the bad bundle leaves S1 and stays set until reset or START.
- FULL is registered from COUNT and asserts the cycle after the final write completes.
- Reset asserted mid-write: the write is abandoned with no completion, and all outputs return to their reset values.

## Test plan

- LUI, RD=1, IMM=0xFFFFF000, MEM_READY=1 -> at edge N+2, write MEM_ADDR=0, MEM_WDATA=0xFFFFF0B7; COUNT=1.
- Back-to-back stream with MEM_READY=1:
  - Bundles: ADDI (RD=1, RS1=0, IMM=-20); BEQ (RS1=1, RS2=2, IMM=8); JAL (RD=1, IMM=0x800); SW (RS1=1, RS2=2, FUNCT3=010, IMM=4); SUB (RD=3, RS1=1, RS2=2, FUNCT7=0x20).
  - Required writes, one per cycle at addresses 0..4: 0xFEC00093, 0x00208463, 0x001000EF, 0x0020A223, 0x402081B3.
- Backpressure:
  - Hold MEM_READY=0 for 5 cycles with 3 bundles offered.
  - Required: MEM_WDATA/MEM_ADDR stable, exactly 2 bundles accepted, IN_READY=0.
  - Release MEM_READY -> all 3 words written in order, no loss or duplication.
- Opcode 0x7F between two valid bundles -> ERR=1, only 2 writes at consecutive addresses 0,1; START -> ERR=0, COUNT=0, next write at address 0.
- ADDR_W=2, BASE_ADDR=2, 5 bundles offered:
  - Required: 4 writes at addresses 2,3,0,1, then FULL=1, COUNT=4, IN_READY=0.
  - The 5th bundle is never accepted.
- RSTN pulsed low while MEM_WE=1 and MEM_READY=0 -> all outputs at reset values immediately, no write completes; next write lands at BASE_ADDR.
